// File: rtl/wb_commit.sv
// Writeback/commit stage.
// Selects the writeback value and drives the register-file write port
// combinationally. Keeps a one-cycle WB-to-ID bypass copy of the last write and
// four commit performance counters for evaluating the branch predictor.
module wb_commit #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_valid,
    input  logic [31:0]      i_pc,
    input  logic [31:0]      i_alu_result,
    input  logic [31:0]      i_mem_data,
    input  logic [31:0]      i_imm_data,
    input  logic [4:0]       i_rd,
    input  logic             i_regwrite,
    input  logic [1:0]       i_wb_sel,
    input  logic             i_is_ctrl,
    input  logic             i_mispred,
    input  logic             i_cnt_en,
    input  logic             i_cnt_clear,
    input  logic [1:0]       i_cnt_sel,
    output logic             o_rf_we,
    output logic [4:0]       o_rf_rd,
    output logic [31:0]      o_rf_wdata,
    output logic             o_fwd_valid,
    output logic [4:0]       o_fwd_rd,
    output logic [31:0]      o_fwd_data,
    output logic [CNT_W-1:0] o_cnt_rdata,
    output logic             o_commit
);

    // Writeback source encodings.
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_IMM = 2'b11;

    // Counter select encodings.
    localparam logic [1:0] SEL_CYCLES  = 2'b00;
    localparam logic [1:0] SEL_INSTRET = 2'b01;
    localparam logic [1:0] SEL_CTRL    = 2'b10;
    localparam logic [1:0] SEL_MISPRED = 2'b11;

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    logic             commit;
    logic             wr;
    logic [31:0]      pc_plus4;
    logic [31:0]      wb_data;

    logic             inc_cycles;
    logic             inc_instret;
    logic             inc_ctrl;
    logic             inc_mispred;

    logic [CNT_W-1:0] cycles_q,  cycles_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic [CNT_W-1:0] ctrl_q,    ctrl_d;
    logic [CNT_W-1:0] mispred_q, mispred_d;
    logic [CNT_W-1:0] cnt_rdata_d;

    logic             fwd_valid_q, fwd_valid_d;
    logic [4:0]       fwd_rd_q,    fwd_rd_d;
    logic [31:0]      fwd_data_q,  fwd_data_d;
    logic             commit_q;

    // Bubbles never commit; writes to x0 are dropped but still retire.
    assign commit   = i_valid;
    assign wr       = i_valid & i_regwrite & (i_rd != 5'd0);
    // Wraps mod 2^32 naturally.
    assign pc_plus4 = i_pc + 32'd4;

    // Writeback source mux; its value is visible even when no write occurs.
    always_comb begin
        wb_data = i_alu_result;
        case (i_wb_sel)
            WB_ALU:  wb_data = i_alu_result;
            WB_MEM:  wb_data = i_mem_data;
            WB_PC4:  wb_data = pc_plus4;
            WB_IMM:  wb_data = i_imm_data;
            default: wb_data = i_alu_result;
        endcase
    end

    assign o_rf_we    = wr;
    assign o_rf_rd    = i_rd;
    assign o_rf_wdata = wb_data;

    // Bypass next state: rd/data hold across non-writing cycles, valid drops.
    always_comb begin
        fwd_valid_d = wr;
        fwd_rd_d    = fwd_rd_q;
        fwd_data_d  = fwd_data_q;
        if (wr) begin
            fwd_rd_d   = i_rd;
            fwd_data_d = wb_data;
        end
    end

    // Counter increment qualifiers, all gated by the global enable.
    always_comb begin
        inc_cycles  = i_cnt_en;
        inc_instret = i_cnt_en & commit;
        inc_ctrl    = i_cnt_en & commit & (i_is_ctrl | i_mispred);
        inc_mispred = i_cnt_en & commit & i_mispred;
    end

    // Counter next state; clear wins over any increment in the same cycle.
    always_comb begin
        cycles_d  = cycles_q;
        instret_d = instret_q;
        ctrl_d    = ctrl_q;
        mispred_d = mispred_q;
        if (i_cnt_clear) begin
            cycles_d  = CNT_ZERO;
            instret_d = CNT_ZERO;
            ctrl_d    = CNT_ZERO;
            mispred_d = CNT_ZERO;
        end else begin
            if (inc_cycles) begin
                cycles_d = cycles_q + CNT_ONE;
            end
            if (inc_instret) begin
                instret_d = instret_q + CNT_ONE;
            end
            if (inc_ctrl) begin
                ctrl_d = ctrl_q + CNT_ONE;
            end
            if (inc_mispred) begin
                mispred_d = mispred_q + CNT_ONE;
            end
        end
    end

    // Readback selects the post-update value so it matches the sampled cycle.
    always_comb begin
        cnt_rdata_d = cycles_d;
        case (i_cnt_sel)
            SEL_CYCLES:  cnt_rdata_d = cycles_d;
            SEL_INSTRET: cnt_rdata_d = instret_d;
            SEL_CTRL:    cnt_rdata_d = ctrl_d;
            SEL_MISPRED: cnt_rdata_d = mispred_d;
            default:     cnt_rdata_d = cycles_d;
        endcase
    end

    // Bypass register and commit pulse.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            fwd_valid_q <= 1'b0;
            fwd_rd_q    <= 5'd0;
            fwd_data_q  <= 32'd0;
            commit_q    <= 1'b0;
        end else begin
            fwd_valid_q <= fwd_valid_d;
            fwd_rd_q    <= fwd_rd_d;
            fwd_data_q  <= fwd_data_d;
            commit_q    <= commit;
        end
    end

    // Performance counters and registered readback; reset beats clear/enable.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            cycles_q    <= CNT_ZERO;
            instret_q   <= CNT_ZERO;
            ctrl_q      <= CNT_ZERO;
            mispred_q   <= CNT_ZERO;
            o_cnt_rdata <= CNT_ZERO;
        end else begin
            cycles_q    <= cycles_d;
            instret_q   <= instret_d;
            ctrl_q      <= ctrl_d;
            mispred_q   <= mispred_d;
            o_cnt_rdata <= cnt_rdata_d;
        end
    end

    assign o_fwd_valid = fwd_valid_q;
    assign o_fwd_rd    = fwd_rd_q;
    assign o_fwd_data  = fwd_data_q;
    assign o_commit    = commit_q;

endmodule

// File: tb/tb_wb_commit.sv
// Self-checking bench for wb_commit: table-driven mux vectors, hand-written
// counter/clear/reset/wrap sequences, and a scoreboard for registered outputs.
module tb_wb_commit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] alu_result;
    logic [31:0] mem_data;
    logic [31:0] imm_data;
    logic [4:0]  rd;
    logic        regwrite;
    logic [1:0]  wb_sel;
    logic        is_ctrl;
    logic        mispred;
    logic        cnt_en;
    logic        cnt_clear;
    logic [1:0]  cnt_sel;

    logic        rf_we, rf_we_16;
    logic [4:0]  rf_rd, rf_rd_16;
    logic [31:0] rf_wdata, rf_wdata_16;
    logic        fwd_valid, fwd_valid_16;
    logic [4:0]  fwd_rd, fwd_rd_16;
    logic [31:0] fwd_data, fwd_data_16;
    logic [31:0] cnt_rdata;
    logic [15:0] cnt_rdata_16;
    logic        commit, commit_16;

    always #5 clk = ~clk;

    wb_commit #(.CNT_W(32)) dut (
        .i_clk(clk), .i_reset_n(reset_n), .i_valid(valid), .i_pc(pc),
        .i_alu_result(alu_result), .i_mem_data(mem_data), .i_imm_data(imm_data),
        .i_rd(rd), .i_regwrite(regwrite), .i_wb_sel(wb_sel), .i_is_ctrl(is_ctrl),
        .i_mispred(mispred), .i_cnt_en(cnt_en), .i_cnt_clear(cnt_clear),
        .i_cnt_sel(cnt_sel), .o_rf_we(rf_we), .o_rf_rd(rf_rd), .o_rf_wdata(rf_wdata),
        .o_fwd_valid(fwd_valid), .o_fwd_rd(fwd_rd), .o_fwd_data(fwd_data),
        .o_cnt_rdata(cnt_rdata), .o_commit(commit)
    );

    wb_commit #(.CNT_W(16)) dut16 (
        .i_clk(clk), .i_reset_n(reset_n), .i_valid(valid), .i_pc(pc),
        .i_alu_result(alu_result), .i_mem_data(mem_data), .i_imm_data(imm_data),
        .i_rd(rd), .i_regwrite(regwrite), .i_wb_sel(wb_sel), .i_is_ctrl(is_ctrl),
        .i_mispred(mispred), .i_cnt_en(cnt_en), .i_cnt_clear(cnt_clear),
        .i_cnt_sel(cnt_sel), .o_rf_we(rf_we_16), .o_rf_rd(rf_rd_16),
        .o_rf_wdata(rf_wdata_16), .o_fwd_valid(fwd_valid_16), .o_fwd_rd(fwd_rd_16),
        .o_fwd_data(fwd_data_16), .o_cnt_rdata(cnt_rdata_16), .o_commit(commit_16)
    );

    typedef struct {
        logic        fv;
        logic [4:0]  frd;
        logic [31:0] fdata;
        logic        cmt;
        logic [31:0] cnt32;
        logic [15:0] cnt16;
    } exp_t;

    typedef struct {
        logic        valid;
        logic        regwrite;
        logic [4:0]  rd;
        logic [1:0]  sel;
        logic [31:0] pc;
        logic        mispred;
        logic        exp_we;
        logic [31:0] exp_wdata;
    } vec_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model state (64-bit so both widths are slices of one count).
    logic [63:0] m_cyc, m_ins, m_ctl, m_mis;
    logic        m_fv;
    logic [4:0]  m_frd;
    logic [31:0] m_fdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mux_model(input logic [1:0] s);
        logic [31:0] r;
        if (s == 2'd0)      r = alu_result;
        else if (s == 2'd1) r = mem_data;
        else if (s == 2'd2) r = pc + 32'd4;
        else                r = imm_data;
        return r;
    endfunction

    // Check combinational outputs, push expected registered outputs, clock once,
    // then pop and compare against both instances.
    task automatic step();
        logic        w;
        logic [31:0] wd;
        logic [63:0] s;
        exp_t        e;
        exp_t        g;
        #1;
        w  = valid & regwrite & (rd != 5'd0);
        wd = mux_model(wb_sel);
        chk("rf_we", rf_we, w);
        chk("rf_rd", rf_rd, rd);
        chk("rf_wdata", rf_wdata, wd);
        chk("rf_we_16", rf_we_16, w);
        if (!reset_n) begin
            m_cyc = 0; m_ins = 0; m_ctl = 0; m_mis = 0;
            m_fv = 0; m_frd = 0; m_fdata = 0;
            e.cmt = 1'b0;
        end else begin
            m_fv = w;
            if (w) begin
                m_frd   = rd;
                m_fdata = wd;
            end
            e.cmt = valid;
            if (cnt_clear) begin
                m_cyc = 0; m_ins = 0; m_ctl = 0; m_mis = 0;
            end else if (cnt_en) begin
                m_cyc = m_cyc + 1;
                if (valid) m_ins = m_ins + 1;
                if (valid && (is_ctrl || mispred)) m_ctl = m_ctl + 1;
                if (valid && mispred) m_mis = m_mis + 1;
            end
        end
        if (cnt_sel == 2'd0)      s = m_cyc;
        else if (cnt_sel == 2'd1) s = m_ins;
        else if (cnt_sel == 2'd2) s = m_ctl;
        else                      s = m_mis;
        e.fv    = m_fv;
        e.frd   = m_frd;
        e.fdata = m_fdata;
        e.cnt32 = s[31:0];
        e.cnt16 = s[15:0];
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_underflow");
        end else begin
            g = sb.pop_front();
            chk("fwd_valid", fwd_valid, g.fv);
            chk("fwd_rd", fwd_rd, g.frd);
            chk("fwd_data", fwd_data, g.fdata);
            chk("commit", commit, g.cmt);
            chk("cnt_rdata", cnt_rdata, g.cnt32);
            chk("cnt_rdata_16", cnt_rdata_16, g.cnt16);
            chk("fwd_valid_16", fwd_valid_16, g.fv);
            chk("commit_16", commit_16, g.cmt);
        end
    endtask

    task automatic idle_inputs();
        valid = 0; regwrite = 0; rd = 0; wb_sel = 0; is_ctrl = 0; mispred = 0;
        cnt_en = 0; cnt_clear = 0; cnt_sel = 0;
    endtask

    vec_t        vt[7];
    logic [9:0]  pv, pc_bits, pm;
    logic [31:0] rb_exp[4];

    initial begin
        m_cyc = 0; m_ins = 0; m_ctl = 0; m_mis = 0;
        m_fv = 0; m_frd = 0; m_fdata = 0;
        alu_result = 32'h11; mem_data = 32'h22; imm_data = 32'h33000; pc = 32'h100;
        idle_inputs();
        reset_n = 0;
        cnt_en = 1; cnt_clear = 1;
        step();
        chk("reset_fwd_valid", fwd_valid, 0);
        chk("reset_cnt", cnt_rdata, 0);
        chk("reset_commit", commit, 0);
        reset_n = 1;
        cnt_clear = 0;

        // Mux sweep, PC+4 wrap, x0 write and bubble.
        vt[0] = '{1, 1, 5, 2'd0, 32'h100, 0, 1, 32'h11};
        vt[1] = '{1, 1, 5, 2'd1, 32'h100, 0, 1, 32'h22};
        vt[2] = '{1, 1, 5, 2'd2, 32'h100, 0, 1, 32'h104};
        vt[3] = '{1, 1, 5, 2'd3, 32'h100, 0, 1, 32'h33000};
        vt[4] = '{1, 1, 9, 2'd2, 32'hFFFFFFFC, 0, 1, 32'h0};
        vt[5] = '{1, 1, 0, 2'd0, 32'h100, 0, 0, 32'h11};
        vt[6] = '{0, 1, 5, 2'd1, 32'h100, 1, 0, 32'h22};
        cnt_en  = 1;
        cnt_sel = 2'd1;
        for (int i = 0; i < 7; i++) begin
            valid = vt[i].valid; regwrite = vt[i].regwrite; rd = vt[i].rd;
            wb_sel = vt[i].sel; pc = vt[i].pc; mispred = vt[i].mispred;
            #1;
            chk("tbl_we", rf_we, vt[i].exp_we);
            chk("tbl_wdata", rf_wdata, vt[i].exp_wdata);
            step();
            chk("tbl_fwd_valid", fwd_valid, vt[i].exp_we);
            if (vt[i].exp_we) chk("tbl_fwd_data", fwd_data, vt[i].exp_wdata);
        end
        // 6 commits so far (5 writes + x0 write); the bubble did not count.
        chk("tbl_instret", cnt_rdata, 6);
        pc = 32'h100;

        // Back-to-back writes to the same rd: bypass holds the newest.
        idle_inputs();
        valid = 1; regwrite = 1; rd = 7; wb_sel = 0; alu_result = 32'hAAAA;
        step();
        alu_result = 32'hBBBB;
        step();
        chk("b2b_fwd_rd", fwd_rd, 7);
        chk("b2b_fwd_data", fwd_data, 32'hBBBB);
        // Non-writing cycle: valid drops, rd/data hold.
        valid = 0;
        step();
        chk("hold_fwd_valid", fwd_valid, 0);
        chk("hold_fwd_data", fwd_data, 32'hBBBB);
        alu_result = 32'h11;

        // Counters: clear, then 10 enabled cycles with 6 commits, 3 ctrl, 1 mispred.
        idle_inputs();
        cnt_clear = 1; cnt_en = 1; valid = 1; mispred = 1;
        step();
        cnt_clear = 0;
        pv = 10'b0101011011;
        pc_bits = 10'b0001010110;
        pm = 10'b0001000100;
        for (int i = 0; i < 10; i++) begin
            valid = pv[i]; is_ctrl = pc_bits[i]; mispred = pm[i];
            regwrite = pv[i]; rd = 5'(i + 1);
            step();
        end
        idle_inputs();
        rb_exp[0] = 10; rb_exp[1] = 6; rb_exp[2] = 3; rb_exp[3] = 1;
        for (int i = 0; i < 4; i++) begin
            cnt_sel = 2'(i);
            step();
            chk("cnt_readback", cnt_rdata, rb_exp[i]);
        end

        // Clear has priority over a valid mispredicted commit.
        idle_inputs();
        cnt_clear = 1; cnt_en = 1; valid = 1; is_ctrl = 1; mispred = 1; cnt_sel = 2'd3;
        step();
        chk("clr_prio", cnt_rdata, 0);
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            cnt_sel = 2'(i);
            step();
            chk("clr_zero", cnt_rdata, 0);
        end
        valid = 1; cnt_en = 1; cnt_sel = 2'd1;
        step();
        chk("clr_then_instret", cnt_rdata, 1);

        // Reset mid-operation: nonzero counters and a live bypass entry.
        idle_inputs();
        valid = 1; regwrite = 1; rd = 3; cnt_en = 1; cnt_sel = 2'd0;
        step();
        chk("pre_reset_fwd_valid", fwd_valid, 1);
        reset_n = 0;
        step();
        chk("rst_fwd_valid", fwd_valid, 0);
        chk("rst_fwd_rd", fwd_rd, 0);
        chk("rst_fwd_data", fwd_data, 0);
        chk("rst_cnt", cnt_rdata, 0);
        chk("rst_commit", commit, 0);
        reset_n = 1;
        idle_inputs();
        valid = 1; cnt_en = 1; cnt_sel = 2'd1;
        step();
        chk("post_reset_instret", cnt_rdata, 1);

        // Wrap: 16-bit counter reaches 0xFFFF then rolls to 0; 32-bit keeps going.
        idle_inputs();
        cnt_clear = 1;
        step();
        cnt_clear = 0; cnt_en = 1; cnt_sel = 2'd0;
        repeat (65535) @(posedge clk);
        #1;
        chk("wrap16_max", cnt_rdata_16, 16'hFFFF);
        chk("wrap32_pre", cnt_rdata, 32'hFFFF);
        @(posedge clk);
        #1;
        chk("wrap16_zero", cnt_rdata_16, 16'h0000);
        chk("wrap32_post", cnt_rdata, 32'h10000);
        chk("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wb_commit.md
# wb_commit

Writeback/commit stage. Sits directly downstream of the MEM/WB pipeline register. It selects the writeback value and drives the register-file write port. It holds a one-cycle WB-to-ID bypass copy of the last write, and keeps commit performance counters (cycles, retired instructions, control-flow instructions, mispredictions) used to evaluate the gshare predictor.

## Interface
- CNT_W, 32, width of each performance counter (16..64)
- i_clk  in  1  clock, all state updates on rising edge
- i_reset_n  in  1  synchronous active-low reset
- i_valid  in  1  instruction in WB is real (not a bubble)
- i_pc  in  32  PC of WB instruction
- i_alu_result  in  32  ALU result
- i_mem_data  in  32  load data (already sign/zero extended by LSU)
- i_imm_data  in  32  immediate (LUI path)
- i_rd  in  5  destination register
- i_regwrite  in  1  instruction writes rd
- i_wb_sel  in  2  00 ALU, 01 MEM, 10 PC+4, 11 IMM
- i_is_ctrl  in  1  branch/jump
- i_mispred  in  1  predictor was wrong for this instruction
- i_cnt_en  in  1  counters advance when 1
- i_cnt_clear  in  1  zero all counters
- i_cnt_sel  in  2  00 cycles, 01 instret, 10 ctrl, 11 mispred
- o_rf_we  out  1  register-file write enable (combinational)
- o_rf_rd  out  5  register-file write address (combinational)
- o_rf_wdata  out  32  register-file write data (combinational)
- o_fwd_valid  out  1  registered: last cycle wrote a nonzero rd
- o_fwd_rd  out  5  registered copy of written rd
- o_fwd_data  out  32  registered copy of written data
- o_cnt_rdata  out  CNT_W  registered counter selected by i_cnt_sel
- o_commit  out  1  registered pulse: one instruction retired last cycle

## Operation
- Commit condition: commit = i_valid.
- Write condition: wr = i_valid & i_regwrite & (i_rd != 0).
- o_rf_we = wr, o_rf_rd = i_rd, o_rf_wdata = mux(i_wb_sel).
- PC+4 is computed mod 2^32: 0xFFFFFFFC gives 0x00000000.
- When wr=0, o_rf_wdata still shows the mux value. Only o_rf_we gates the write.
- Bypass register: on wr, o_fwd_valid<=1, o_fwd_rd<=i_rd, o_fwd_data<=o_rf_wdata. Otherwise o_fwd_valid<=0 and rd/data hold their previous values.
- Counters:
  - cycles: increments every cycle with i_cnt_en=1.
  - instret: increments on commit.
  - ctrl: increments on commit & (i_is_ctrl | i_mispred).
  - mispred: increments on commit & i_mispred.
  - All increments are gated by i_cnt_en.
- Bubbles (i_valid=0) never count, even when i_mispred or i_is_ctrl are 1.
- Counters wrap modulo 2^CNT_W. There is no saturation and no overflow flag.
- i_cnt_clear has priority over increment in the same cycle: the result is 0, not 1.
- o_cnt_rdata <= value of the selected counter after this cycle's update, so it reflects the cycle in which i_cnt_sel was sampled.
- o_commit <= commit.

## Timing
- RF write path has zero latency. The register file captures on the same edge, and ID reads the new value next cycle via o_fwd_*.
- Bypass, o_commit and o_cnt_rdata have 1-cycle latency.
- Reset (i_reset_n=0 at an edge) forces:
  - o_fwd_valid=0, o_fwd_rd=0, o_fwd_data=0
  - all counters 0, o_cnt_rdata=0, o_commit=0
- Reset overrides i_cnt_clear and i_cnt_en.
- Combinational outputs follow their inputs during reset. Upstream MEM/WB reset holds i_valid=0, so o_rf_we=0.
- Reset mid-count discards all counts. Counting restarts from 0 the first cycle after release when i_cnt_en=1.
- Back-to-back writes to the same rd: the bypass holds the newest write.

## Test plan
- Mux: i_valid=1, regwrite=1, rd=5, alu=0x11, mem=0x22, imm=0x33000, pc=0x100, sweeping wb_sel 00..11 -> o_rf_wdata = 0x11, 0x22, 0x104, 0x33000. o_fwd_data equals the same sequence one cycle later.
- x0 and bubble: rd=0 with regwrite=1 -> o_rf_we=0, o_fwd_valid=0 next cycle, instret +1. i_valid=0 with regwrite=1, mispred=1 -> no write, no counter change except cycles.
- Counters: cnt_en=1, 10 cycles with 6 valid of which 3 ctrl and 1 mispred -> cycles=10, instret=6, ctrl=3, mispred=1, read back via cnt_sel 00..11.
- Wrap: CNT_W=16, preload cycles to 0xFFFF by running 65535 cycles -> next cycle reads 0x0000.
- Clear priority: i_cnt_clear=1 together with a valid mispred commit -> all counters 0 next cycle. The following commit reads instret=1.
- Reset mid-operation: counters nonzero and o_fwd_valid=1, assert i_reset_n=0 for one edge -> all registered outputs 0. Counting resumes from 0.
